myproject_sdiv_39s_31ns_8s_seq: RTL and testbench

Sequential signed divider, the inverse of the 31ns×8s→39 multiplier datapath. Takes a 39-bit signed product and a 31-bit unsigned divisor, and recovers an 8-bit signed quotient plus a signed remainder. Uses radix-2 restoring division, one bit per enabled cycle, behind a start/done handshake. Instantiated by HLS-generated datapaths wherever a scaled product must be rescaled.

---
 rtl/myproject_sdiv_pkg.sv | 19 +
 rtl/myproject_sdiv_step.sv | 33 +++
 rtl/myproject_sdiv_39s_31ns_8s_seq.sv | 172 +++++++++++++++++
 tb/tb_myproject_sdiv_39s_31ns_8s_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/myproject_sdiv_pkg.sv
// Shared types and default sizing for the sequential signed divider.
package myproject_sdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam int W0 = 39;  // signed dividend width
  localparam int W1 = 31;  // unsigned divisor width
  localparam int WQ = 8;   // signed quotient width

  localparam int QMAX = (1 << (WQ - 1)) - 1;
  localparam int QMIN = -(1 << (WQ - 1));

  localparam int CNT_W = $clog2(W0 + 1);

endpackage

// File: rtl/myproject_sdiv_step.sv
// One radix-2 restoring division step on magnitudes: shifts the next
// dividend bit into the partial remainder, subtracts the divisor when it
// fits, and shifts the resulting quotient bit into the low end of mag.
module myproject_sdiv_step
  import myproject_sdiv_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = W0,
  parameter int DIVISOR_WIDTH  = W1
) (
  input  logic [DIVISOR_WIDTH-1:0]  prem_i,
  input  logic [DIVIDEND_WIDTH-1:0] mag_i,
  input  logic [DIVISOR_WIDTH-1:0]  dvs_i,
  output logic [DIVISOR_WIDTH-1:0]  prem_o,
  output logic [DIVIDEND_WIDTH-1:0] mag_o
);

  localparam int DW = DIVIDEND_WIDTH;
  localparam int VW = DIVISOR_WIDTH;

  logic [VW:0] shifted;
  logic [VW:0] diff;
  logic        qbit;

  // Trial subtraction; the remainder stays below the divisor, so VW bits hold it.
  always_comb begin
    shifted = {prem_i, mag_i[DW-1]};
    diff    = shifted - {1'b0, dvs_i};
    qbit    = (shifted >= {1'b0, dvs_i});
    prem_o  = qbit ? diff[VW-1:0] : shifted[VW-1:0];
    mag_o   = {mag_i[DW-2:0], qbit};
  end

endmodule

// File: rtl/myproject_sdiv_39s_31ns_8s_seq.sv
// Sequential signed / unsigned divider with saturated signed quotient and
// signed remainder (sign of dividend), start/done handshake, clock enable.
module myproject_sdiv_39s_31ns_8s_seq
  import myproject_sdiv_pkg::*;
#(
  parameter int ID             = 1,
  parameter int DIVIDEND_WIDTH = W0,
  parameter int DIVISOR_WIDTH  = W1,
  parameter int QUOT_WIDTH     = WQ
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic                      start,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      ready,
  output logic                      done,
  output logic [QUOT_WIDTH-1:0]     quot,
  output logic [DIVISOR_WIDTH:0]    remd,
  output logic                      ovf,
  output logic                      dbz
);

  localparam int DW = DIVIDEND_WIDTH;
  localparam int VW = DIVISOR_WIDTH;
  localparam int QW = QUOT_WIDTH;
  localparam int CW = $clog2(DW + 1);

  localparam logic [DW-1:0] POS_LIM = DW'((1 << (QW - 1)) - 1);
  localparam logic [DW-1:0] NEG_LIM = DW'(1 << (QW - 1));
  localparam logic [QW-1:0] Q_MAX   = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0] Q_MIN   = {1'b1, {(QW-1){1'b0}}};

  // Applies the sign to the quotient magnitude and clamps; MSB is the overflow flag.
  function automatic logic [QW:0] sat_quot(input logic neg, input logic [DW-1:0] mag);
    logic [QW-1:0] q;
    logic          of;
    if (neg) begin
      of = (mag > NEG_LIM);
      q  = of ? Q_MIN : -mag[QW-1:0];
    end else begin
      of = (mag > POS_LIM);
      q  = of ? Q_MAX : mag[QW-1:0];
    end
    return {of, q};
  endfunction

  // Remainder takes the dividend's sign (truncating division).
  function automatic logic [VW:0] signed_remd(input logic neg, input logic [VW-1:0] prem);
    logic [VW:0] r;
    r = {1'b0, prem};
    return neg ? -r : r;
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sign_q, sign_d;
  logic [VW-1:0] prem_q, prem_d;
  logic [DW-1:0] mag_q, mag_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic          done_q, done_d;
  logic [QW-1:0] quot_q, quot_d;
  logic [VW:0]   remd_q, remd_d;
  logic          ovf_q, ovf_d;
  logic          dbz_q, dbz_d;

  logic [VW-1:0] prem_step;
  logic [DW-1:0] mag_step;
  logic [QW:0]   sat;

  myproject_sdiv_step #(
    .DIVIDEND_WIDTH (DW),
    .DIVISOR_WIDTH  (VW)
  ) u_step (
    .prem_i (prem_q),
    .mag_i  (mag_q),
    .dvs_i  (dvs_q),
    .prem_o (prem_step),
    .mag_o  (mag_step)
  );

  // Next-state and datapath update; everything holds while ce is low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    prem_d  = prem_q;
    mag_d   = mag_q;
    dvs_d   = dvs_q;
    done_d  = done_q;
    quot_d  = quot_q;
    remd_d  = remd_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    sat     = sat_quot(sign_q, mag_q);
    if (ce) begin
      done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sign_d  = dividend[DW-1];
            mag_d   = dividend[DW-1] ? -dividend : dividend;
            dvs_d   = divisor;
            prem_d  = '0;
            cnt_d   = CW'(DW);
            state_d = CALC;
          end
        end
        CALC: begin
          prem_d = prem_step;
          mag_d  = mag_step;
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = FIX;
        end
        FIX: begin
          done_d  = 1'b1;
          state_d = IDLE;
          if (dvs_q == '0) begin
            dbz_d  = 1'b1;
            ovf_d  = 1'b0;
            remd_d = '0;
            quot_d = sign_q ? Q_MIN : Q_MAX;
          end else begin
            dbz_d  = 1'b0;
            ovf_d  = sat[QW];
            quot_d = sat[QW-1:0];
            remd_d = signed_remd(sign_q, prem_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      remd_q  <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      remd_q  <= remd_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  // Working operands; always loaded on start before use, so no reset needed.
  always_ff @(posedge clk) begin
    sign_q <= sign_d;
    prem_q <= prem_d;
    mag_q  <= mag_d;
    dvs_q  <= dvs_d;
  end

  assign ready = (state_q == IDLE);
  assign done  = done_q;
  assign quot  = quot_q;
  assign remd  = remd_q;
  assign ovf   = ovf_q;
  assign dbz   = dbz_q;

endmodule

// File: tb/tb_myproject_sdiv_39s_31ns_8s_seq.sv
// Bench for the sequential signed divider: directed cases plus random
// operands, expected results queued at issue and checked by a monitor.
module tb_myproject_sdiv_39s_31ns_8s_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ce = 1'b1;
  logic        start = 1'b0;
  logic [38:0] dividend = '0;
  logic [30:0] divisor = '0;
  logic        ready, done, ovf, dbz;
  logic [7:0]  quot;
  logic [31:0] remd;

  myproject_sdiv_39s_31ns_8s_seq dut (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .ready    (ready),
    .done     (done),
    .quot     (quot),
    .remd     (remd),
    .ovf      (ovf),
    .dbz      (dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  q;
    logic [31:0] r;
    logic        ovf;
    logic        dbz;
    int          edges;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic last_en = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    last_en <= ce;
  end

  task automatic chk(input string name, input logic signed [63:0] got,
                     input logic signed [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: plain truncating 64-bit division, then clamp to 8 bits.
  function automatic exp_t model(input logic [38:0] dd, input logic [30:0] dv);
    exp_t   e;
    longint n, d, q, r;
    n = longint'($signed(dd));
    d = longint'({1'b0, dv});
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    e.edges = 41;
    e.start_cyc = 0;
    if (d == 0) begin
      e.dbz = 1'b1;
      e.q   = (n >= 0) ? 8'h7f : 8'h80;
      e.r   = '0;
    end else begin
      q = n / d;
      r = n % d;
      if (q > 127) begin
        e.q = 8'h7f; e.ovf = 1'b1;
      end else if (q < -128) begin
        e.q = 8'h80; e.ovf = 1'b1;
      end else begin
        e.q = q[7:0];
      end
      e.r = r[31:0];
    end
    return e;
  endfunction

  // Monitor: checks each fresh done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (done && last_en) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("quot", $signed(quot), $signed(mon_e.q));
          chk("remd", $signed(remd), $signed(mon_e.r));
          chk("ovf", ovf, mon_e.ovf);
          chk("dbz", dbz, mon_e.dbz);
          chk("latency", cyc - mon_e.start_cyc, mon_e.edges);
          chk("ready_at_done", ready, 1);
        end
      end else if (sb.size() > 0 && !done) begin
        chk("ready_busy", ready, 0);
      end
    end
  end

  // Called at a negedge with the DUT idle and ce high.
  task automatic issue(input logic [38:0] dd, input logic [30:0] dv, input int edges);
    exp_t e;
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clk);
    e = model(dd, dv);
    e.edges = edges;
    e.start_cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    dividend = 39'({$urandom(), $urandom()});
    divisor  = 31'($urandom());
  endtask

  task automatic wait_done(input int lim);
    int n;
    n = 0;
    while (!done && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    #1 reset = 1'b1;
    #2;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_quot", quot, 0);
    chk("rst_remd", remd, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dbz", dbz, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    issue(39'd100, 31'd7, 41);
    wait_done(100);
    issue(-39'sd100, 31'd7, 41);
    wait_done(100);
    issue(-39'sd274877906816, 31'd2147483647, 41);
    wait_done(100);
    issue(39'd1000, 31'd7, 41);
    wait_done(100);
    issue(39'h40_0000_0000, 31'd1, 41);
    wait_done(100);
    issue(-39'sd5, 31'd0, 41);
    wait_done(100);
    issue(39'd0, 31'd0, 41);
    wait_done(100);

    // Stall with ce low for 10 edges and try to restart while busy.
    @(negedge clk);
    issue(-39'sd123456, 31'd1000, 51);
    repeat (5) @(negedge clk);
    ce = 1'b0;
    repeat (10) @(negedge clk);
    ce = 1'b1;
    repeat (3) @(negedge clk);
    dividend = 39'd999;
    divisor  = 31'd2;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done(100);

    // Abort mid-calculation with an asynchronous reset.
    @(negedge clk);
    issue(39'd5000, 31'd3, 41);
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_ready", ready, 1);
    chk("abort_done", done, 0);
    chk("abort_quot", quot, 0);
    chk("abort_remd", remd, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_dbz", dbz, 0);
    sb.delete();
    @(negedge clk);
    #2 reset = 1'b0;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("no_done_after_reset", seen, 0);
    issue(39'd5000, 31'd3, 41);
    wait_done(100);

    for (int i = 0; i < 24; i++) begin
      logic [63:0] r64;
      logic [38:0] dd;
      logic [30:0] dv;
      int          v;
      r64 = {$urandom(), $urandom()};
      case ($urandom_range(0, 3))
        0: begin dd = r64[38:0]; dv = 31'($urandom()); end
        1: begin v = int'($urandom_range(0, 300000)) - 150000; dd = 39'(v);
                 dv = 31'($urandom_range(1, 2000)); end
        2: begin dd = r64[38:0]; dv = '0; end
        default: begin v = int'($urandom_range(0, 80000)) - 40000; dd = 39'(v);
                       dv = 31'($urandom_range(1, 255)); end
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(dd, dv, 41);
      wait_done(100);
    end

    repeat (3) @(negedge clk);
    chk("drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
